// File: rtl/obstacle_scroller_pkg.sv
// obstacle_scroller_pkg
//   Shared definitions for the obstacle field stage of the car game.
//   - state_t     : 3-bit FSM encoding (IDLE, RUN, SHIFT, CHECK, OVER)
//   - LFSR_TAPS   : Galois feedback mask for x^8+x^6+x^5+x^4+1
//   - SCORE_MAX   : saturation value of the 8-bit score
//   - lfsr_next   : one Galois step (right shift, xor taps when bit 0 falls out)
//   - seed_fix    : maps the forbidden all-zero seed onto 8'h01
package obstacle_scroller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] SCORE_MAX = 8'd255;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    logic [7:0] shifted;
    shifted = q >> 1;
    return q[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

  // An all-zero state would lock the LFSR forever.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr
//   8-bit Galois LFSR that supplies the random spawn pattern.
//   Ports:
//     Clock   in  1  system clock
//     Resetn  in  1  asynchronous active-low reset, loads seed
//     step    in  1  advance the sequence by one state
//     seed    in  8  reset value (zero is replaced by 8'h01)
//     q       out 8  current LFSR state
module obstacle_lfsr
  import obstacle_scroller_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] lfsr_reg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr_reg <= seed_fix(seed);
    end else if (step) begin
      lfsr_reg <= lfsr_next(lfsr_reg);
    end
  end

  assign q = lfsr_reg;

endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller
//   Advances the car game's obstacle field on each speed tick, spawns a
//   pseudo-random top row, detects car/obstacle collisions, counts cleared
//   rows and holds game-over until restart.
//   Ports:
//     Clock       in   1           system clock
//     Resetn      in   1           asynchronous active-low reset
//     Tick        in   1           one-cycle move pulse from the speed stage
//     Start       in   1           level, begin/restart a game
//     PlayerLane  in   3           car lane, values >= LANES clamp to LANES-1
//     Obstacles   out  ROWS*LANES  field, row r lane l at bit r*LANES+l
//     Collision   out  1           one-cycle pulse on crash
//     GameOver    out  1           high from crash until restart/reset
//     Running     out  1           high in RUN/SHIFT/CHECK
//     Score       out  8           cleared non-empty rows, saturating
module obstacle_scroller
  import obstacle_scroller_pkg::*;
#(
  parameter int         ROWS  = 8,
  parameter int         LANES = 3,
  parameter int         GAP   = 1,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Tick,
  input  logic                  Start,
  input  logic [2:0]            PlayerLane,
  output logic [ROWS*LANES-1:0] Obstacles,
  output logic                  Collision,
  output logic                  GameOver,
  output logic                  Running,
  output logic [7:0]            Score
);

  localparam int FW = ROWS * LANES;

  state_t          state_reg, state_next;
  logic [FW-1:0]   field_reg, field_next;
  logic [7:0]      score_reg, score_next;
  logic [3:0]      gap_reg, gap_next;
  logic            collision_reg, collision_next;

  logic [7:0]      lfsr_q;
  logic            lfsr_step;

  logic [2:0]      lane_eff;
  logic [LANES-1:0] bottom_row;
  logic [7:0]      bottom_pad;
  logic            bottom_hit;
  logic [LANES-1:0] spawn_pat;
  logic [3:0]      gap_after;
  logic [FW-1:0]   shifted;
  logic [8:0]      score_inc;
  logic [7:0]      score_sat;

  obstacle_lfsr u_lfsr (
    .Clock  (Clock),
    .Resetn (Resetn),
    .step   (lfsr_step),
    .seed   (SEED),
    .q      (lfsr_q)
  );

  // Only the low LANES bits of the LFSR feed the spawn pattern.
  generate
    if (LANES < 8) begin : g_unused
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^lfsr_q[7:LANES];
    end
  endgenerate

  // Compare in 4 bits so LANES=8 does not wrap to zero.
  assign lane_eff = ({1'b0, PlayerLane} >= 4'(LANES)) ? 3'(LANES - 1) : PlayerLane;

  assign bottom_row = field_reg[(ROWS-1)*LANES +: LANES];

  // Pad the bottom row to 8 bits so the 3-bit lane index fits exactly.
  always_comb begin
    bottom_pad = '0;
    bottom_pad[LANES-1:0] = bottom_row;
  end
  assign bottom_hit = bottom_pad[lane_eff];

  // Spawn pattern and gap counter update used by SHIFT.
  always_comb begin
    spawn_pat = '0;
    gap_after = gap_reg;
    if (gap_reg != 4'd0) begin
      gap_after = gap_reg - 4'd1;
    end else begin
      spawn_pat = lfsr_q[LANES-1:0];
      // Never block every lane: the car must always have an escape.
      if (&spawn_pat) begin
        spawn_pat[0] = 1'b0;
      end
      if (|spawn_pat) begin
        gap_after = 4'(GAP);
      end
    end
  end

  // Field moves down one row; the new pattern enters at row 0.
  assign shifted[LANES-1:0] = spawn_pat;
  genvar gi;
  generate
    for (gi = 1; gi < ROWS; gi++) begin : g_shift
      assign shifted[gi*LANES +: LANES] = field_reg[(gi-1)*LANES +: LANES];
    end
  endgenerate

  assign score_inc = {1'b0, score_reg} + 9'd1;
  assign score_sat = (score_inc > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_inc[7:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= ST_IDLE;
      field_reg     <= '0;
      score_reg     <= '0;
      gap_reg       <= '0;
      collision_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      field_reg     <= field_next;
      score_reg     <= score_next;
      gap_reg       <= gap_next;
      collision_reg <= collision_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    field_next     = field_reg;
    score_next     = score_reg;
    gap_next       = gap_reg;
    collision_next = 1'b0;
    lfsr_step      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (Start) begin
          state_next = ST_RUN;
          field_next = '0;
          score_next = '0;
        end
      end

      ST_RUN: begin
        // A crash caused by steering beats a simultaneous tick.
        if (bottom_hit) begin
          state_next     = ST_OVER;
          collision_next = 1'b1;
        end else if (Tick) begin
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        field_next = shifted;
        gap_next   = gap_after;
        lfsr_step  = 1'b1;
        if (|bottom_row) begin
          score_next = score_sat;
        end
        state_next = ST_CHECK;
      end

      ST_CHECK: begin
        if (bottom_hit) begin
          state_next     = ST_OVER;
          collision_next = 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end

      ST_OVER: begin
        // Restart clears like IDLE entry and resumes play immediately.
        if (Start) begin
          state_next = ST_RUN;
          field_next = '0;
          score_next = '0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign Obstacles = field_reg;
  assign Collision = collision_reg;
  assign GameOver  = (state_reg == ST_OVER);
  assign Running   = (state_reg == ST_RUN) || (state_reg == ST_SHIFT) || (state_reg == ST_CHECK);
  assign Score     = score_reg;

endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller
//   Directed bench for obstacle_scroller with ROWS=8, LANES=3, GAP=1,
//   SEED=8'hA5. A small reference model of the spawn sequence provides the
//   expected field and score; hand-computed constants anchor the first ticks.
module tb_obstacle_scroller;

  localparam int         ROWS  = 8;
  localparam int         LANES = 3;
  localparam int         GAP   = 1;
  localparam logic [7:0] SEED  = 8'hA5;
  localparam int         FW    = ROWS * LANES;

  logic          Clock;
  logic          Resetn;
  logic          Tick;
  logic          Start;
  logic [2:0]    PlayerLane;
  logic [FW-1:0] Obstacles;
  logic          Collision;
  logic          GameOver;
  logic          Running;
  logic [7:0]    Score;

  int tests_run    = 0;
  int tests_failed = 0;
  int tick_no      = 0;

  logic [7:0]    m_lfsr;
  int            m_gap;
  logic [FW-1:0] m_field;
  int            m_score;

  obstacle_scroller #(
    .ROWS  (ROWS),
    .LANES (LANES),
    .GAP   (GAP),
    .SEED  (SEED)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Tick       (Tick),
    .Start      (Start),
    .PlayerLane (PlayerLane),
    .Obstacles  (Obstacles),
    .Collision  (Collision),
    .GameOver   (GameOver),
    .Running    (Running),
    .Score      (Score)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] row_of(input logic [FW-1:0] f, input int r);
    return f[r*LANES +: LANES];
  endfunction

  task automatic model_reset_all();
    m_lfsr  = SEED;
    m_gap   = 0;
    m_field = '0;
    m_score = 0;
  endtask

  task automatic model_tick();
    logic [2:0] pat;
    if (row_of(m_field, ROWS-1) != 3'b000) m_score = (m_score >= 255) ? 255 : m_score + 1;
    if (m_gap != 0) begin
      pat = 3'b000;
      m_gap--;
    end else begin
      pat = m_lfsr[2:0];
      if (pat == 3'b111) pat = 3'b110;
      if (pat != 3'b000) m_gap = GAP;
    end
    m_field = {m_field[FW-LANES-1:0], pat};
    m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
  endtask

  // Pick a lane clear in both the current bottom row and the row about to drop into it.
  task automatic steer();
    logic [2:0] r6, r7;
    int chosen;
    r6 = row_of(m_field, ROWS-2);
    r7 = row_of(m_field, ROWS-1);
    chosen = -1;
    for (int l = 0; l < LANES; l++) begin
      if (chosen < 0 && !r6[l] && !r7[l]) chosen = l;
    end
    if (chosen >= 0) PlayerLane = 3'(chosen);
  endtask

  // One Tick from RUN; ends #1 after the edge where the collision verdict lands.
  task automatic do_tick();
    logic [2:0] prev_row0;
    prev_row0 = row_of(m_field, 0);
    Tick = 1'b1;
    @(posedge Clock); #1;
    Tick = 1'b0;
    model_tick();
    @(posedge Clock); #1;
    check("field", 32'(Obstacles), 32'(m_field));
    check("score", 32'(Score), 32'(m_score));
    check("no_full_row", 32'(row_of(Obstacles, 0) == 3'b111), 32'd0);
    if (prev_row0 != 3'b000) check("gap_row", 32'(row_of(Obstacles, 0)), 32'd0);
    @(posedge Clock); #1;
    check("no_collision", 32'(Collision), 32'd0);
    check("running", 32'(Running), 32'd1);
    tick_no++;
    $display("[TB] tick %0d lane=%0d field=%06h score=%0d", tick_no, PlayerLane, Obstacles, Score);
  endtask

  initial begin
    logic [FW-1:0] frozen;
    logic [2:0]    r7;
    int            extra;
    int            found;

    Resetn = 1'b0;
    Tick = 1'b0;
    Start = 1'b0;
    PlayerLane = 3'd0;
    model_reset_all();

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("rst_obstacles", 32'(Obstacles), 32'd0);
    check("rst_score", 32'(Score), 32'd0);
    check("rst_collision", 32'(Collision), 32'd0);
    check("rst_gameover", 32'(GameOver), 32'd0);
    check("rst_running", 32'(Running), 32'd0);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    check("idle_waits", 32'(Running), 32'd0);
    $display("[TB] reset released, idle");

    // Start and golden spawn sequence
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check("start_running", 32'(Running), 32'd1);
    $display("[TB] start -> running=%0d", Running);
    for (int i = 0; i < 4; i++) begin
      steer();
      do_tick();
    end
    check("hand_field4", 32'(Obstacles), 32'h000A28);
    for (int i = 0; i < 40 && m_score < 5; i++) begin
      steer();
      do_tick();
    end
    check("score_5", 32'(Score), 32'd5);
    check("pre_reset_nonzero", 32'(Obstacles != '0), 32'd1);

    // Asynchronous reset while in SHIFT
    Tick = 1'b1;
    @(posedge Clock); #1;
    Tick = 1'b0;
    Resetn = 1'b0;
    #2;
    check("midshift_obstacles", 32'(Obstacles), 32'd0);
    check("midshift_score", 32'(Score), 32'd0);
    check("midshift_collision", 32'(Collision), 32'd0);
    check("midshift_gameover", 32'(GameOver), 32'd0);
    check("midshift_running", 32'(Running), 32'd0);
    $display("[TB] async reset during shift");
    model_reset_all();
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
    check("post_reset_idle", 32'(Running), 32'd0);

    // Restart with car in lane 2: the first spawned row (lanes 0,2) hits at tick 8
    PlayerLane = 3'd2;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) do_tick();
    check("lfsr_reseeded", 32'(Obstacles), 32'h000A28);
    for (int i = 0; i < 3; i++) do_tick();
    Tick = 1'b1;
    @(posedge Clock); #1;
    Tick = 1'b0;
    model_tick();
    @(posedge Clock); #1;
    check("hit_field", 32'(Obstacles), 32'(m_field));
    check("hit_row7", 32'(row_of(Obstacles, ROWS-1)), 32'd5);
    check("coll_k1", 32'(Collision), 32'd0);
    @(posedge Clock); #1;
    check("coll_k2", 32'(Collision), 32'd1);
    check("over_k2", 32'(GameOver), 32'd1);
    check("stop_k2", 32'(Running), 32'd0);
    @(posedge Clock); #1;
    check("coll_pulse", 32'(Collision), 32'd0);
    check("over_held", 32'(GameOver), 32'd1);
    $display("[TB] crash at tick 8, field=%06h", Obstacles);
    frozen = m_field;
    for (int i = 0; i < 3; i++) begin
      Tick = 1'b1;
      @(posedge Clock); #1;
      Tick = 1'b0;
      @(posedge Clock); #1;
      check("frozen", 32'(Obstacles), 32'(frozen));
      check("frozen_coll", 32'(Collision), 32'd0);
      $display("[TB] tick in OVER, field=%06h", Obstacles);
    end

    // Start in OVER restarts play
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    m_field = '0;
    m_score = 0;
    check("restart1_obstacles", 32'(Obstacles), 32'd0);
    check("restart1_running", 32'(Running), 32'd1);
    check("restart1_gameover", 32'(GameOver), 32'd0);
    $display("[TB] restart from OVER");

    // Start during RUN and Tick held through SHIFT/CHECK are ignored
    for (int i = 0; i < 3; i++) begin
      steer();
      do_tick();
    end
    steer();
    Start = 1'b1;
    @(posedge Clock); #1;
    check("start_in_run", 32'(Obstacles), 32'(m_field));
    check("start_in_run_running", 32'(Running), 32'd1);
    Tick = 1'b1;
    @(posedge Clock); #1;
    model_tick();
    @(posedge Clock); #1;
    check("held_tick_field", 32'(Obstacles), 32'(m_field));
    @(posedge Clock); #1;
    Tick = 1'b0;
    Start = 1'b0;
    check("held_tick_running", 32'(Running), 32'd1);
    @(posedge Clock); #1;
    check("tick_not_queued", 32'(Obstacles), 32'(m_field));
    $display("[TB] held tick + start in run, field=%06h", Obstacles);

    // Long run until the score saturates
    extra = 0;
    for (int i = 0; i < 1500 && extra < 20; i++) begin
      steer();
      do_tick();
      if (m_score == 255) extra++;
    end
    check("score_sat", 32'(Score), 32'd255);

    // Steer onto an occupied bottom lane (lane 7 clamps to lane 2) without a Tick
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      r7 = row_of(m_field, ROWS-1);
      if (r7[2]) begin
        found = 1;
      end else begin
        steer();
        do_tick();
      end
    end
    check("lane2_occupied", 32'(found), 32'd1);
    PlayerLane = 3'd7;
    @(posedge Clock); #1;
    check("steer_coll", 32'(Collision), 32'd1);
    check("steer_over", 32'(GameOver), 32'd1);
    check("steer_stop", 32'(Running), 32'd0);
    @(posedge Clock); #1;
    check("steer_coll_pulse", 32'(Collision), 32'd0);
    $display("[TB] steered crash, score=%0d", Score);

    // Restart from OVER clears a saturated score
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check("restart2_score", 32'(Score), 32'd0);
    check("restart2_obstacles", 32'(Obstacles), 32'd0);
    check("restart2_running", 32'(Running), 32'd1);
    check("restart2_gameover", 32'(GameOver), 32'd0);
    $display("[TB] restart from OVER, score=%0d", Score);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
